logic_gate_pipe: RTL
====================

# logic_gate_pipe

Parametrised, pipelined bitwise logic unit: the registered, multi-function successor to the fixed two-bit OR cell mapping. Takes two WIDTH-bit operands per beat over a valid/ready handshake, applies one of eight 74xx-style gate functions (including an OR-accumulate across a burst), and presents the result through a two-entry output buffer. Sits between cell-level datapath logic and any consumer that can stall.

## Interface
- WIDTH, 8, operand/result width in bits (1..64).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  input beat present.
- in_ready  out  1  unit can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  function: 0 OR, 1 AND, 2 XOR, 3 NOR, 4 NAND, 5 XNOR, 6 OR-accumulate, 7 pass A.
- in_last  in  1  marks final beat of a burst.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- y  out  WIDTH  result.
- out_last  out  1  last flag travelling with result.

## Operation
- Input accepted when in_valid && in_ready at a rising edge; output consumed when out_valid && out_ready.
- Ops 0-5, 7: one result per accepted beat; y = bitwise function of a, b; out_last = in_last.
- Op 6: internal WIDTH-bit acc. Beat with in_last=0: acc <= acc | a | b, no result emitted. Beat with in_last=1: emits y = acc | a | b, out_last=1; acc <= 0 same edge.
- acc touched only by op-6 beats; other ops between op-6 beats leave acc unchanged and are emitted normally.
- Storage: output register (OR) and skid register (SK). States by occupancy:
  - EMPTY: OR, SK invalid. Result-producing accept -> ONE.
  - ONE: OR valid. Accept + consume -> ONE (new result into OR). Accept, no consume -> FULL (new result into SK). Consume, no accept -> EMPTY.
  - FULL: OR and SK valid. Consume -> ONE (SK moves to OR). No accept possible.
- Op-6 non-last beats cause no state transition but still require in_ready.
- in_ready = !SK valid (registered state only; no combinational in_ready from out_ready).
- Strict in-order delivery; no beat dropped or duplicated.
- y and out_last hold stable while out_valid && !out_ready.
- Unused op values: none (all 8 defined).

## Timing
- Reset (asynchronous assert, synchronous release on next clk edge): out_valid=0, y=0, out_last=0, acc=0, SK invalid, in_ready=1.
- Latency: beat accepted at edge k -> out_valid=1 with its result during cycle after edge k (1 cycle).
- Throughput: 1 beat/cycle while out_ready held high.
- Stall: out_ready low with OR full -> one further beat absorbed into SK; in_ready low from next cycle until OR consumed.
- Simultaneous accept and consume in FULL cannot occur (in_ready=0).
- Reset mid-burst: pending op-6 accumulation and both buffer entries discarded.
- WIDTH=1 legal; all functions bitwise, no carries, no width extension.

## Test plan
- WIDTH=8, out_ready=1, op=0, a=0x0F, b=0xF0 -> y=0xFF, out_valid one cycle after accept; repeat ops 1-5, 7 with a=0xCC, b=0xAA -> 0x88, 0x66, 0x11, 0x77, 0x99, 0xCC.
- Op 6 burst: (0x01,0x02,last0), (0x10,0x00,last0), (0x00,0x80,last1) -> single result y=0x93, out_last=1; next burst (0x04,0x00,last1) -> y=0x04 (acc cleared).
- Backpressure: out_ready=0, stream beats 1,2,3 op=7 -> in_ready drops after second accept; release out_ready -> y=1,2,3 in order, one per cycle, y stable while stalled.
- Full throughput: 16 beats op=2, in_valid and out_ready held 1 -> 16 results, no bubbles, in_ready constant 1.
- Async reset asserted mid-stall in FULL and mid op-6 burst -> out_valid=0, y=0, in_ready=1 immediately; next op-6 last beat a=0x01,b=0 -> y=0x01.
- Interleave: op-6 (0x01,last0), op=0 (0x20,0x00), op-6 (0x00,0x02,last1) -> results 0x20 then 0x03.

Source files
------------

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: pipelined bitwise gate unit with valid/ready handshake.
// Eight gate functions, including an OR-accumulate across a burst, feed a
// two-entry output buffer (output register plus skid register) so the
// input side can absorb one extra beat while the consumer stalls.
module logic_gate_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             out_last
);

  // Occupancy of the output register / skid register pair.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] or_data_q, or_data_d;
  logic             or_last_q, or_last_d;
  logic [WIDTH-1:0] sk_data_q, sk_data_d;
  logic             sk_last_q, sk_last_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             accept;
  logic             consume;
  logic             produce;
  logic             is_acc_op;
  logic [WIDTH-1:0] result;

  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  assign is_acc_op = (op == 3'd6);
  // An accumulate beat only yields a result when it closes the burst.
  assign produce   = accept && !(is_acc_op && !in_last);

  // Gate function selected by op; the accumulate case folds in the running OR.
  always_comb begin
    result = '0;
    case (op)
      3'd0:    result = a | b;
      3'd1:    result = a & b;
      3'd2:    result = a ^ b;
      3'd3:    result = ~(a | b);
      3'd4:    result = ~(a & b);
      3'd5:    result = ~(a ^ b);
      3'd6:    result = acc_q | a | b;
      default: result = a;
    endcase
  end

  // Accumulator only moves on accepted accumulate beats; the closing beat clears it.
  always_comb begin
    acc_d = acc_q;
    if (accept && is_acc_op) begin
      if (in_last) begin
        acc_d = '0;
      end else begin
        acc_d = acc_q | a | b;
      end
    end
  end

  // State register for buffer occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy from result production and consumer acceptance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (produce) state_d = ST_ONE;
      end
      ST_ONE: begin
        if (produce && !consume)      state_d = ST_FULL;
        else if (!produce && consume) state_d = ST_EMPTY;
      end
      ST_FULL: begin
        if (consume) state_d = ST_ONE;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Handshake outputs come from registered state only, never from out_ready.
  always_comb begin
    in_ready  = (state_q != ST_FULL);
    out_valid = (state_q != ST_EMPTY);
    y         = or_data_q;
    out_last  = or_last_q;
  end

  // Steer new results into the output or skid register, and shift skid forward.
  always_comb begin
    or_data_d = or_data_q;
    or_last_d = or_last_q;
    sk_data_d = sk_data_q;
    sk_last_d = sk_last_q;
    case (state_q)
      ST_EMPTY: begin
        if (produce) begin
          or_data_d = result;
          or_last_d = in_last;
        end
      end
      ST_ONE: begin
        if (produce && consume) begin
          or_data_d = result;
          or_last_d = in_last;
        end else if (produce) begin
          sk_data_d = result;
          sk_last_d = in_last;
        end
      end
      ST_FULL: begin
        if (consume) begin
          or_data_d = sk_data_q;
          or_last_d = sk_last_q;
        end
      end
      default: begin
        or_data_d = or_data_q;
      end
    endcase
  end

  // Datapath registers; reset discards buffered results and any partial burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_data_q <= '0;
      or_last_q <= 1'b0;
      sk_data_q <= '0;
      sk_last_q <= 1'b0;
      acc_q     <= '0;
    end else begin
      or_data_q <= or_data_d;
      or_last_q <= or_last_d;
      sk_data_q <= sk_data_d;
      sk_last_q <= sk_last_d;
      acc_q     <= acc_d;
    end
  end

endmodule
